// File: rtl/cbus_arbiter_if.sv
`default_nettype none
// ============================================================================
// cbus_pkg / cbus_arbiter_if
// Request/response record types of the cbus, and the bundle of bus signals
// around cbus_arbiter: per-requester request/response arrays plus the single
// downstream request/response pair.
// Revision: 1.0 - initial release
// ============================================================================

package cbus_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;     // log2 of bytes per beat
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;      // beats in burst minus one
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// The arbiter acts as the cbus master towards the memory slave, so it takes
// the master modport; requesters and the slave model sit on the slave modport.
interface cbus_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport master (
    input  ireqs,
    output iresps,
    output oreq,
    input  oresp
  );

  modport slave (
    output ireqs,
    input  iresps,
    input  oreq,
    output oresp
  );

endinterface

`default_nettype wire

// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
// cbus_arbiter
// Round-robin arbiter sharing one cbus master port among NUM_INPUTS
// requesters. A grant is held for the whole burst, until the ready && last
// beat; requests and responses are passed through combinationally.
// Revision: 1.0 - initial release
// ============================================================================

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic           clk,
  input  logic           reset,
  cbus_arbiter_if.master bus
);

  localparam int SEL_W = $clog2(NUM_INPUTS);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_INPUTS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] sel, sel_nx;
  logic [SEL_W-1:0] last_grant, last_grant_nx;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] cand;
  logic             any_valid;

  // Round-robin search starting just after the most recent grant, so the
  // requester that finished last gets the lowest priority.
  always_comb begin
    winner    = last_grant;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = SEL_W'((int'(last_grant) + k) % NUM_INPUTS);
      if (!any_valid && bus.ireqs[cand].valid) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  // State register; reset leaves input 0 with first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= SEL_LAST;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      last_grant <= last_grant_nx;
    end
  end

  // Next-state and bus muxing. While BUSY the grant is locked regardless of
  // the requester valids; only the slave's final beat releases it.
  always_comb begin
    state_nx      = state;
    sel_nx        = sel;
    last_grant_nx = last_grant;
    bus.oreq      = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      bus.iresps[i] = '0;
    end

    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nx      = BUSY;
          sel_nx        = winner;
          last_grant_nx = winner;
        end
      end
      BUSY: begin
        bus.oreq        = bus.ireqs[sel];
        bus.iresps[sel] = bus.oresp;
        if (bus.oresp.ready && bus.oresp.last) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
